// File: rtl/ctrl_pkg.sv
// Shared opcode/funct constants, PCSrc and ALUFun codes, and the ID/EX control
// bundle type used by the registered decoder.
package ctrl_pkg;

    typedef logic [2:0] pcsrc_t;
    typedef logic [5:0] alufun_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam pcsrc_t PC_SEQ  = 3'b000;
    localparam pcsrc_t PC_BR   = 3'b001;
    localparam pcsrc_t PC_JMP  = 3'b010;
    localparam pcsrc_t PC_JR   = 3'b011;
    localparam pcsrc_t PC_IRQ  = 3'b100;
    localparam pcsrc_t PC_EXC  = 3'b101;
    localparam pcsrc_t PC_JALR = 3'b110;

    localparam alufun_t ALU_ADD = 6'b000000;
    localparam alufun_t ALU_SUB = 6'b000001;
    localparam alufun_t ALU_AND = 6'b011000;
    localparam alufun_t ALU_OR  = 6'b011110;
    localparam alufun_t ALU_XOR = 6'b010110;
    localparam alufun_t ALU_NOR = 6'b010001;
    localparam alufun_t ALU_SLL = 6'b100000;
    localparam alufun_t ALU_SRL = 6'b100001;
    localparam alufun_t ALU_SRA = 6'b100011;
    localparam alufun_t ALU_SLT = 6'b110101;
    localparam alufun_t ALU_EQ  = 6'b110011;
    localparam alufun_t ALU_NE  = 6'b110001;
    localparam alufun_t ALU_LEZ = 6'b111101;
    localparam alufun_t ALU_GTZ = 6'b111111;
    localparam alufun_t ALU_LTZ = 6'b111011;

    typedef struct packed {
        pcsrc_t     pcsrc;
        logic       sign;
        logic       regwrite;
        logic [1:0] regdst;
        logic       memread;
        logic       memwrite;
        logic [1:0] memtoreg;
        logic       alusrc1;
        logic       alusrc2;
        logic       extop;
        logic       luop;
        alufun_t    alufun;
    } control_bundle_t;

    localparam control_bundle_t BUBBLE = '0;
    localparam control_bundle_t IRQ_BUNDLE = '{
        pcsrc: PC_IRQ, sign: 1'b0, regwrite: 1'b1, regdst: 2'b11,
        memread: 1'b0, memwrite: 1'b0, memtoreg: 2'b11, alusrc1: 1'b0,
        alusrc2: 1'b0, extop: 1'b0, luop: 1'b0, alufun: ALU_ADD};

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op <= OP_ANDI) || (op == OP_LUI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ctrl_decode_irq_if.sv
// Bundle of decode inputs and ID/EX outputs shared by the IF/ID side and EX side.
interface ctrl_decode_irq_if
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) ();
    logic [5:0]          op_code;
    logic [5:0]          funct;
    logic                id_valid;
    logic                stall;
    logic                flush;
    logic                kernel_mode;
    logic [NUM_IRQ-1:0]  irq_src;

    pcsrc_t              ex_pcsrc;
    logic                ex_sign, ex_regwrite, ex_memread, ex_memwrite;
    logic                ex_alusrc1, ex_alusrc2, ex_extop, ex_luop;
    logic [1:0]          ex_regdst;
    logic [1:0]          ex_memtoreg;
    alufun_t             ex_alufun;
    logic                ex_valid;
    logic                irq_taken;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [NUM_IRQ-1:0]  irq_pending;

    modport master (
        output op_code, funct, id_valid, stall, flush, kernel_mode, irq_src,
        input  ex_pcsrc, ex_sign, ex_regwrite, ex_memread, ex_memwrite,
               ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_regdst,
               ex_memtoreg, ex_alufun, ex_valid, irq_taken, irq_id, irq_pending
    );

    modport slave (
        input  op_code, funct, id_valid, stall, flush, kernel_mode, irq_src,
        output ex_pcsrc, ex_sign, ex_regwrite, ex_memread, ex_memwrite,
               ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_regdst,
               ex_memtoreg, ex_alufun, ex_valid, irq_taken, irq_id, irq_pending
    );
endinterface

// File: rtl/irq_arbiter.sv
// Rising-edge detection, pending latch and lowest-index arbitration for the
// external interrupt lines, plus the qualifier that commits a take.
module irq_arbiter #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  i_irq_src,
    input  logic                i_kernel_mode,
    input  logic                i_id_valid,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic [NUM_IRQ-1:0]  o_pending,
    output logic                o_take,
    output logic [IRQ_ID_W-1:0] o_winner
);
    logic [NUM_IRQ-1:0]  r_hist;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_clear;
    logic [IRQ_ID_W-1:0] w_winner;
    logic                w_take;

    assign w_edge = i_irq_src & ~r_hist;

    // Scan high-to-low so the lowest set index is the last one written.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_pending[i]) w_winner = IRQ_ID_W'(i);
        end
    end

    assign w_take  = (|r_pending) & ~i_kernel_mode & i_id_valid & ~i_stall & ~i_flush;
    assign w_clear = w_take ? (NUM_IRQ'(1) << w_winner) : '0;

    // A fresh edge on the winner in its own take cycle re-arms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist    <= '0;
            r_pending <= '0;
        end else begin
            r_hist    <= i_irq_src;
            r_pending <= (r_pending & ~w_clear) | w_edge;
        end
    end

    assign o_pending = r_pending;
    assign o_take    = w_take;
    assign o_winner  = w_winner;
endmodule

// File: rtl/ctrl_decode_irq.sv
// ID-stage control decoder with a registered ID/EX boundary, stall/flush
// handling and multi-line prioritised interrupt injection.
module ctrl_decode_irq
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic         clk,
    input  logic         reset,
    ctrl_decode_irq_if.slave bus
);
    control_bundle_t     w_dec;
    control_bundle_t     r_ex;
    logic                r_valid;
    logic                r_taken;
    logic [IRQ_ID_W-1:0] r_irq_id;
    logic                w_take;
    logic [IRQ_ID_W-1:0] w_winner;
    logic                w_rtype;
    logic                w_branch;

    irq_arbiter #(.NUM_IRQ(NUM_IRQ), .IRQ_ID_W(IRQ_ID_W)) u_arb (
        .clk           (clk),
        .reset         (reset),
        .i_irq_src     (bus.irq_src),
        .i_kernel_mode (bus.kernel_mode),
        .i_id_valid    (bus.id_valid),
        .i_stall       (bus.stall),
        .i_flush       (bus.flush),
        .o_pending     (bus.irq_pending),
        .o_take        (w_take),
        .o_winner      (w_winner)
    );

    assign w_rtype  = (bus.op_code == OP_R);
    assign w_branch = bus.op_code inside {OP_BLTZ, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};

    always_comb begin
        w_dec = BUBBLE;
        if (w_branch)                                    w_dec.pcsrc = PC_BR;
        else if (bus.op_code inside {OP_J, OP_JAL})      w_dec.pcsrc = PC_JMP;
        else if (w_rtype && bus.funct == FN_JR)          w_dec.pcsrc = PC_JR;
        else if (w_rtype && bus.funct == FN_JALR)        w_dec.pcsrc = PC_JALR;
        w_dec.sign     = !((w_rtype && bus.funct == FN_SLTU) || bus.op_code == OP_SLTIU);
        w_dec.regwrite = !(bus.op_code == OP_SW || w_branch || bus.op_code == OP_J ||
                           (w_rtype && bus.funct == FN_JR));
        w_dec.regdst   = (bus.op_code == OP_JAL) ? 2'b10 : (w_rtype ? 2'b01 : 2'b00);
        w_dec.memread  = (bus.op_code == OP_LW);
        w_dec.memwrite = (bus.op_code == OP_SW);
        if (bus.op_code == OP_LW)                        w_dec.memtoreg = 2'b01;
        else if (bus.op_code == OP_JAL || (w_rtype && bus.funct == FN_JALR))
                                                         w_dec.memtoreg = 2'b10;
        w_dec.alusrc1  = w_rtype && (bus.funct inside {FN_SLL, FN_SRL, FN_SRA});
        w_dec.alusrc2  = !(w_rtype || bus.op_code == OP_BEQ);
        w_dec.extop    = (bus.op_code != OP_ANDI);
        w_dec.luop     = (bus.op_code == OP_LUI);
        if (w_rtype) begin
            case (bus.funct)
                FN_SUB, FN_SUBU: w_dec.alufun = ALU_SUB;
                FN_AND:          w_dec.alufun = ALU_AND;
                FN_OR:           w_dec.alufun = ALU_OR;
                FN_XOR:          w_dec.alufun = ALU_XOR;
                FN_NOR:          w_dec.alufun = ALU_NOR;
                FN_SLL:          w_dec.alufun = ALU_SLL;
                FN_SRL:          w_dec.alufun = ALU_SRL;
                FN_SRA:          w_dec.alufun = ALU_SRA;
                FN_SLT, FN_SLTU: w_dec.alufun = ALU_SLT;
                default:         w_dec.alufun = ALU_ADD;
            endcase
        end else begin
            case (bus.op_code)
                OP_ANDI:           w_dec.alufun = ALU_AND;
                OP_SLTI, OP_SLTIU: w_dec.alufun = ALU_SLT;
                OP_BEQ:            w_dec.alufun = ALU_EQ;
                OP_BNE:            w_dec.alufun = ALU_NE;
                OP_BLEZ:           w_dec.alufun = ALU_LEZ;
                OP_BGTZ:           w_dec.alufun = ALU_GTZ;
                OP_BLTZ:           w_dec.alufun = ALU_LTZ;
                default:           w_dec.alufun = ALU_ADD;
            endcase
        end
        // Illegal opcodes redirect to the exception vector and link the PC.
        if (!is_legal_op(bus.op_code)) begin
            w_dec.pcsrc    = PC_EXC;
            w_dec.regdst   = 2'b11;
            w_dec.memtoreg = 2'b10;
            w_dec.regwrite = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex     <= BUBBLE;
            r_valid  <= 1'b0;
            r_taken  <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_taken <= w_take;
            if (bus.flush) begin
                r_ex    <= BUBBLE;
                r_valid <= 1'b0;
            end else if (bus.stall) begin
                r_ex    <= r_ex;
                r_valid <= r_valid;
            end else if (w_take) begin
                r_ex     <= IRQ_BUNDLE;
                r_valid  <= 1'b1;
                r_irq_id <= w_winner;
            end else if (!bus.id_valid) begin
                r_ex    <= BUBBLE;
                r_valid <= 1'b0;
            end else begin
                r_ex    <= w_dec;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.ex_pcsrc    = r_ex.pcsrc;
    assign bus.ex_sign     = r_ex.sign;
    assign bus.ex_regwrite = r_ex.regwrite;
    assign bus.ex_regdst   = r_ex.regdst;
    assign bus.ex_memread  = r_ex.memread;
    assign bus.ex_memwrite = r_ex.memwrite;
    assign bus.ex_memtoreg = r_ex.memtoreg;
    assign bus.ex_alusrc1  = r_ex.alusrc1;
    assign bus.ex_alusrc2  = r_ex.alusrc2;
    assign bus.ex_extop    = r_ex.extop;
    assign bus.ex_luop     = r_ex.luop;
    assign bus.ex_alufun   = r_ex.alufun;
    assign bus.ex_valid    = r_valid;
    assign bus.irq_taken   = r_taken;
    assign bus.irq_id      = r_irq_id;
endmodule
